ysyx_25030093_mem_arbiter: RTL and testbench

YSYX_25030093_MEM_ARBITER -- requirements
Module: ysyx_25030093_mem_arbiter

---
 rtl/ysyx_25030093_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ysyx_25030093_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030093_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single memory port: round-robin on contention,
// one outstanding transaction, timeout abort with a sticky error flag.
module ysyx_25030093_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        mem_reqValid,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic        err
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT_IFU, GRANT_LSU, RELEASE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prio_lsu_q, prio_lsu_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          wen_q, wen_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          ifu_resp_q, ifu_resp_d, lsu_resp_q, lsu_resp_d;
  logic [31:0]   ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic          err_q, err_d;
  logic          done;
  logic [31:0]   done_data;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_lsu_d  = prio_lsu_q;
    mem_req_d   = mem_req_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    ifu_resp_d  = 1'b0;
    lsu_resp_d  = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    err_d       = err_q;
    done        = 1'b0;
    done_data   = mem_rdata;
    unique case (state_q)
      IDLE: begin
        // prio_lsu_q moves only on contested arbitration; solo grants leave it alone
        if (ifu_reqValid && (!lsu_reqValid || !prio_lsu_q)) begin
          state_d   = GRANT_IFU;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          addr_d    = ifu_addr;
          size_d    = 2'b10;
          wen_d     = 1'b0;
          wdata_d   = '0;
          wmask_d   = '0;
          if (lsu_reqValid) prio_lsu_d = 1'b1;
        end else if (lsu_reqValid) begin
          state_d   = GRANT_LSU;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          addr_d    = lsu_addr;
          size_d    = lsu_size;
          wen_d     = lsu_wen;
          wdata_d   = lsu_wdata;
          wmask_d   = lsu_wmask;
          if (ifu_reqValid) prio_lsu_d = 1'b0;
        end
      end
      GRANT_IFU, GRANT_LSU: begin
        // a response arriving on the expiring cycle still wins over the abort
        if (mem_respValid) begin
          done = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          done      = 1'b1;
          done_data = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (done) begin
          mem_req_d = 1'b0;
          state_d   = RELEASE;
          if (state_q == GRANT_LSU) begin
            lsu_resp_d  = 1'b1;
            lsu_rdata_d = done_data;
          end else begin
            ifu_resp_d  = 1'b1;
            ifu_rdata_d = done_data;
          end
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prio_lsu_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_lsu_q  <= prio_lsu_d;
      mem_req_q   <= mem_req_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      ifu_resp_q  <= ifu_resp_d;
      lsu_resp_q  <= lsu_resp_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_reqValid  = mem_req_q;
  assign mem_addr      = addr_q;
  assign mem_size      = size_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_respValid = ifu_resp_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_respValid = lsu_resp_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign err           = err_q;
endmodule

// File: tb/tb_ysyx_25030093_mem_arbiter.sv
// Scoreboarded bench for the IFU/LSU memory arbiter, built with TIMEOUT=4.
module tb_ysyx_25030093_mem_arbiter;
  logic        clock = 1'b0, reset;
  logic        ifu_reqValid, ifu_respValid, lsu_reqValid, lsu_respValid, lsu_wen;
  logic [31:0] ifu_addr, ifu_rdata, lsu_addr, lsu_wdata, lsu_rdata;
  logic [1:0]  lsu_size, mem_size;
  logic [3:0]  lsu_wmask, mem_wmask;
  logic        mem_reqValid, mem_wen, mem_respValid, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  ysyx_25030093_mem_arbiter #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
    .mem_reqValid(mem_reqValid), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        lsu;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0, checks = 0;
  int          cyc_n = 0, resp_cyc = 0, mem_starts = 0, mem_delay = 2, mem_cyc = 0;
  logic        err_m = 1'b0, lsu_hold = 1'b0, lsu_drop_pending = 1'b0, mem_prev = 1'b0;
  logic [31:0] last_ifu = '0, last_lsu = '0;

  always @(posedge clock) cyc_n <= cyc_n + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_A5A5);
  endfunction

  // memory: answers mem_delay cycles into the request, never if mem_delay is large
  initial begin
    mem_respValid = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(negedge clock);
      mem_respValid = 1'b0;
      if (reset || !mem_reqValid) mem_cyc = 0;
      else begin
        if (mem_cyc == mem_delay) begin
          mem_respValid = 1'b1;
          mem_rdata     = memf(mem_addr);
        end
        mem_cyc++;
      end
    end
  end

  // monitor: request fields against the head entry, responses pop it
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (mem_reqValid) begin
          if (sb.size() == 0) chk("mem_unexpected", 32'(mem_reqValid), 32'd0);
          else begin
            e = sb[0];
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_size", 32'(mem_size), 32'(e.size));
            chk("mem_wen", 32'(mem_wen), 32'(e.wen));
            chk("mem_wdata", mem_wdata, e.wdata);
            chk("mem_wmask", 32'(mem_wmask), 32'(e.wmask));
          end
          if (!mem_prev) mem_starts++;
        end
        if (ifu_respValid || lsu_respValid) begin
          if (sb.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("resp_who", 32'(lsu_respValid), 32'(e.lsu));
            chk("resp_both", 32'(ifu_respValid & lsu_respValid), 32'd0);
            chk("resp_rdata", lsu_respValid ? lsu_rdata : ifu_rdata, e.rdata);
            chk("other_rdata_hold", lsu_respValid ? ifu_rdata : lsu_rdata,
                lsu_respValid ? last_ifu : last_lsu);
            chk("resp_err", 32'(err), 32'(e.err));
            if (e.lsu) last_lsu = e.rdata;
            else last_ifu = e.rdata;
          end
          resp_cyc = cyc_n;
          if (ifu_respValid) ifu_reqValid = 1'b0;
          if (lsu_respValid) begin
            if (lsu_hold) lsu_drop_pending = 1'b1;
            else lsu_reqValid = 1'b0;
          end
        end else if (lsu_drop_pending) begin
          lsu_reqValid     = 1'b0;
          lsu_drop_pending = 1'b0;
        end
      end
      mem_prev = mem_reqValid;
    end
  end

  task automatic exp_ifu(logic [31:0] a, logic to);
    exp_t e;
    if (to) err_m = 1'b1;
    e = '{lsu: 1'b0, addr: a, size: 2'b10, wen: 1'b0, wdata: 32'h0, wmask: 4'h0,
          rdata: to ? 32'h0 : memf(a), err: err_m};
    sb.push_back(e);
  endtask

  task automatic exp_lsu(logic [31:0] a, logic [1:0] s, logic w, logic [31:0] wd,
                         logic [3:0] wm, logic to);
    exp_t e;
    if (to) err_m = 1'b1;
    e = '{lsu: 1'b1, addr: a, size: s, wen: w, wdata: wd, wmask: wm,
          rdata: to ? 32'h0 : memf(a), err: err_m};
    sb.push_back(e);
  endtask

  task automatic req_ifu(logic [31:0] a);
    ifu_addr = a; ifu_reqValid = 1'b1;
  endtask

  task automatic req_lsu(logic [31:0] a, logic [1:0] s, logic w, logic [31:0] wd, logic [3:0] wm);
    lsu_addr = a; lsu_size = s; lsu_wen = w; lsu_wdata = wd; lsu_wmask = wm;
    lsu_reqValid = 1'b1;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((sb.size() != 0 || ifu_reqValid || lsu_reqValid) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_memreq(int budget);
    int n = 0;
    while (!mem_reqValid && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("memreq_seen", 32'(mem_reqValid), 32'd1);
  endtask

  initial begin
    int start, starts0;
    reset = 1'b1;
    ifu_reqValid = 1'b0; ifu_addr = '0;
    lsu_reqValid = 1'b0; lsu_addr = '0; lsu_size = '0; lsu_wen = 1'b0;
    lsu_wdata = '0; lsu_wmask = '0;
    repeat (2) @(negedge clock);
    chk("rst_mem_req", 32'(mem_reqValid), 32'd0);
    chk("rst_resp", 32'({ifu_respValid, lsu_respValid}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rdata", ifu_rdata | lsu_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // IFU-only fetch, memory answers two cycles into the request
    mem_delay = 2; start = cyc_n;
    exp_ifu(32'h8000_0000, 1'b0); req_ifu(32'h8000_0000);
    drain(30);
    chk("lat_fetch", 32'(resp_cyc - start), 32'd4);

    // zero-wait memory gives the minimum latency
    mem_delay = 0; start = cyc_n;
    exp_ifu(32'h8000_0100, 1'b0); req_ifu(32'h8000_0100);
    drain(30);
    chk("lat_min", 32'(resp_cyc - start), 32'd2);

    // contested pairs: IFU first after reset, then LSU
    mem_delay = 1;
    exp_ifu(32'h8000_0010, 1'b0); exp_lsu(32'h2000_0004, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0);
    req_ifu(32'h8000_0010); req_lsu(32'h2000_0004, 2'b10, 1'b0, 32'h0, 4'h0);
    drain(40);
    exp_lsu(32'h2000_0008, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0); exp_ifu(32'h8000_0014, 1'b0);
    req_ifu(32'h8000_0014); req_lsu(32'h2000_0008, 2'b10, 1'b0, 32'h0, 4'h0);
    drain(40);

    // byte store; inputs change in flight, response on the last allowed cycle
    mem_delay = 3;
    exp_lsu(32'h1000_0001, 2'b00, 1'b1, 32'h0000_4100, 4'b0010, 1'b0);
    req_lsu(32'h1000_0001, 2'b00, 1'b1, 32'h0000_4100, 4'b0010);
    wait_memreq(10);
    lsu_addr = 32'hDEAD_BEEF; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF; lsu_size = 2'b10;
    drain(30);

    // requester withdraws mid-transaction, response still delivered
    mem_delay = 2;
    exp_ifu(32'h8000_0200, 1'b0); req_ifu(32'h8000_0200);
    wait_memreq(10);
    ifu_reqValid = 1'b0; ifu_addr = 32'h0BAD_0000;
    drain(30);

    // stale level-held valid after the pulse must not re-grant
    mem_delay = 1; lsu_hold = 1'b1; starts0 = mem_starts;
    exp_lsu(32'h2000_0010, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0);
    req_lsu(32'h2000_0010, 2'b10, 1'b0, 32'h0, 4'h0);
    drain(30);
    repeat (3) @(negedge clock);
    chk("no_regrant", 32'(mem_starts - starts0), 32'd1);
    lsu_hold = 1'b0;

    // timeout abort, then err stays set
    mem_delay = 99; start = cyc_n;
    exp_lsu(32'h3000_0000, 2'b10, 1'b0, 32'h0, 4'h0, 1'b1);
    req_lsu(32'h3000_0000, 2'b10, 1'b0, 32'h0, 4'h0);
    drain(30);
    chk("lat_timeout", 32'(resp_cyc - start), 32'd5);
    mem_delay = 1;
    exp_ifu(32'h8000_0300, 1'b0); req_ifu(32'h8000_0300);
    drain(30);
    chk("err_sticky", 32'(err), 32'd1);

    // third pair: LSU won last contest, so IFU goes first
    exp_ifu(32'h8000_0020, 1'b0); exp_lsu(32'h2000_0020, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0);
    req_ifu(32'h8000_0020); req_lsu(32'h2000_0020, 2'b10, 1'b0, 32'h0, 4'h0);
    drain(40);

    // async reset in flight: request dropped before any clock edge
    mem_delay = 99;
    exp_lsu(32'h3000_0040, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0);
    req_lsu(32'h3000_0040, 2'b10, 1'b0, 32'h0, 4'h0);
    wait_memreq(10);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_memreq", 32'(mem_reqValid), 32'd0);
    chk("rst_async_err", 32'(err), 32'd0);
    chk("rst_async_rdata", ifu_rdata | lsu_rdata, 32'd0);
    sb.delete(); ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
    err_m = 1'b0; last_ifu = '0; last_lsu = '0;
    @(negedge clock);
    chk("rst_no_pulse", 32'({ifu_respValid, lsu_respValid}), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // pointer back to IFU-first after reset
    mem_delay = 0;
    exp_ifu(32'h8000_0030, 1'b0); exp_lsu(32'h2000_0030, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0);
    req_ifu(32'h8000_0030); req_lsu(32'h2000_0030, 2'b10, 1'b0, 32'h0, 4'h0);
    drain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
